// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
// Shared constants and helpers for the seven-segment display path.
//   SEG_OFF    : active-low segment pattern with every segment dark
//   HEX_FONT   : active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
//   hex_to_seg : nibble -> active-low segment pattern
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_FONT[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_display_ctrl_if.sv
// seven_seg_display_ctrl_if
// Bundles the data/control inputs and the display outputs of the controller.
//   digits/dp_in/blank_in/load : buffered display data and its capture strobe
//   lz_en/brightness           : live display modifiers
//   an/seg/dp                  : active-low display drive
//   frame_done/pending         : scan and buffer status
// master = data source (feeds the controller), slave = the controller.
interface seven_seg_display_ctrl_if #(
  parameter int NUM_DIGITS  = 4,
  parameter int BRIGHT_BITS = 2
);

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load;
  logic                    lz_en;
  logic [BRIGHT_BITS-1:0]  brightness;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_done;
  logic                    pending;

  modport master (
    output digits, dp_in, blank_in, load, lz_en, brightness,
    input  an, seg, dp, frame_done, pending
  );

  modport slave (
    input  digits, dp_in, blank_in, load, lz_en, brightness,
    output an, seg, dp, frame_done, pending
  );

endinterface

// File: rtl/seven_seg_hex_font.sv
// seven_seg_hex_font
// Combinational hex-to-seven-segment decoder.
//   nibble : hex value 0..F
//   seg    : active-low {g,f,e,d,c,b,a}
module seven_seg_hex_font
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// seven_seg_display_ctrl
// Multi-digit seven-segment scanner with its own refresh prescaler,
// frame-synchronous double-buffered display data, decimal points,
// blanking, leading-zero suppression and PWM brightness.
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : slave side of seven_seg_display_ctrl_if (data in, display out)
module seven_seg_display_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIVIDE_BY   = 17,
  parameter int BRIGHT_BITS = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  seven_seg_display_ctrl_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DIVIDE_BY-1:0]    cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*NUM_DIGITS-1:0] act_digits_r;
  logic [NUM_DIGITS-1:0]   act_dp_r;
  logic [NUM_DIGITS-1:0]   act_blank_r;
  logic [4*NUM_DIGITS-1:0] pend_digits_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r;
  logic [NUM_DIGITS-1:0]   pend_blank_r;
  logic                    pending_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic                    frame_done_r;

  logic                    tick_s;
  logic                    wrap_s;
  logic [3:0]              sel_nibble_s;
  logic                    sel_dp_s;
  logic                    sel_blank_s;
  logic [NUM_DIGITS-1:0]   zero_above_s;
  logic                    suppressed_s;
  logic                    pwm_on_s;
  logic                    lit_s;
  logic [NUM_DIGITS-1:0]   an_next_s;
  logic [6:0]              font_seg_s;

  assign tick_s = &cnt_r;
  assign wrap_s = tick_s && (idx_r == LAST_IDX);

  // Select the scanned digit's data and decide whether it is lit this clock.
  always_comb begin
    logic zero_run;
    zero_run     = 1'b1;
    zero_above_s = '0;
    // zero_above_s[i]: nibbles i..NUM_DIGITS-1 are all zero
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run        = zero_run && (act_digits_r[4*i +: 4] == 4'h0);
      zero_above_s[i] = zero_run;
    end
    sel_nibble_s = act_digits_r[4*idx_r +: 4];
    sel_dp_s     = act_dp_r[idx_r];
    sel_blank_s  = act_blank_r[idx_r];
    // Rightmost digit always shows so zero still reads as "0"
    suppressed_s = bus.lz_en && (idx_r != '0) && zero_above_s[idx_r];
    // Top prescaler bits act as the PWM ramp; a full-scale level is always on
    pwm_on_s     = (cnt_r[DIVIDE_BY-1 -: BRIGHT_BITS] <= bus.brightness);
    lit_s        = !sel_blank_s && !suppressed_s && pwm_on_s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_next_s[i] = !(lit_s && (idx_r == IDX_W'(i)));
    end
  end

  seven_seg_hex_font u_font (
    .nibble (sel_nibble_s),
    .seg    (font_seg_s)
  );

  // Refresh prescaler and digit scan index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else begin
      cnt_r <= cnt_r + DIVIDE_BY'(1);
      if (wrap_s) begin
        idx_r <= '0;
      end else if (tick_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Double buffer: loads park in the pending set and commit at the frame wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      act_digits_r  <= '0;
      act_dp_r      <= '0;
      act_blank_r   <= '0;
      pend_digits_r <= '0;
      pend_dp_r     <= '0;
      pend_blank_r  <= '0;
      pending_r     <= 1'b0;
    end else if (bus.load && wrap_s) begin
      // Newest data wins outright; anything still parked is dropped
      act_digits_r <= bus.digits;
      act_dp_r     <= bus.dp_in;
      act_blank_r  <= bus.blank_in;
      pending_r    <= 1'b0;
    end else if (wrap_s && pending_r) begin
      act_digits_r <= pend_digits_r;
      act_dp_r     <= pend_dp_r;
      act_blank_r  <= pend_blank_r;
      pending_r    <= 1'b0;
    end else if (bus.load) begin
      pend_digits_r <= bus.digits;
      pend_dp_r     <= bus.dp_in;
      pend_blank_r  <= bus.blank_in;
      pending_r     <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Registered display drive and frame strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an_r         <= '1;
      seg_r        <= SEG_OFF;
      dp_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_next_s;
      seg_r        <= lit_s ? font_seg_s : SEG_OFF;
      dp_r         <= lit_s ? !sel_dp_s : 1'b1;
      frame_done_r <= wrap_s;
    end
  end

  assign bus.an         = an_r;
  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.frame_done = frame_done_r;
  assign bus.pending    = pending_r;

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// tb_seven_seg_display_ctrl
// Directed scenarios followed by random traffic, every output compared each
// clock against a cycle-count based reference of the display behaviour.
module tb_seven_seg_display_ctrl;

  localparam int ND = 4;
  localparam int DB = 2;
  localparam int BB = 2;
  localparam int SLOT  = 1 << DB;       // clocks per digit slot
  localparam int FRAME = SLOT * ND;     // clocks per frame

  logic clock;
  logic reset;

  seven_seg_display_ctrl_if #(.NUM_DIGITS(ND), .BRIGHT_BITS(BB)) bus ();

  seven_seg_display_ctrl #(
    .NUM_DIGITS (ND),
    .DIVIDE_BY  (DB),
    .BRIGHT_BITS(BB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Glyph table written from the font description
  logic [6:0] font [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int compared = 0;
  int mismatched = 0;

  // Reference state: clocks since reset release plus the two data buffers
  int          n;
  logic [15:0] a_dig, p_dig;
  logic [3:0]  a_dp, p_dp, a_bl, p_bl;
  bit          p_flag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    n = 0;
    a_dig = '0; p_dig = '0; a_dp = '0; p_dp = '0; a_bl = '0; p_bl = '0;
    p_flag = 0;
  endtask

  // One clock: predict, clock, compare. Entered and left at posedge+1.
  task automatic step();
    int c, d;
    bit wrap, supp, lit;
    logic [3:0] nib, e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    c = n % SLOT;
    d = (n / SLOT) % ND;
    wrap = (c == SLOT - 1) && (d == ND - 1);
    nib  = a_dig[4*d +: 4];
    supp = bus.lz_en && (d >= 1) && ((a_dig >> (4 * d)) == 16'd0);
    lit  = !a_bl[d] && !supp && (c <= int'(bus.brightness));
    e_an = 4'hF;
    if (lit) e_an[d] = 1'b0;
    e_seg = lit ? font[nib] : 7'h7F;
    e_dp  = lit ? !a_dp[d] : 1'b1;
    if (bus.load && wrap) begin
      a_dig = bus.digits; a_dp = bus.dp_in; a_bl = bus.blank_in; p_flag = 0;
    end else if (wrap && p_flag) begin
      a_dig = p_dig; a_dp = p_dp; a_bl = p_bl; p_flag = 0;
    end else if (bus.load) begin
      p_dig = bus.digits; p_dp = bus.dp_in; p_bl = bus.blank_in; p_flag = 1;
    end
    @(posedge clock);
    #1;
    n++;
    check("an", 32'(bus.an), 32'(e_an));
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("dp", 32'(bus.dp), 32'(e_dp));
    check("frame_done", 32'(bus.frame_done), 32'(wrap));
    check("pending", 32'(bus.pending), 32'(p_flag));
    bus.load = 1'b0;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic do_load(input logic [15:0] dg, input logic [3:0] dpi, input logic [3:0] bl);
    bus.digits = dg; bus.dp_in = dpi; bus.blank_in = bl; bus.load = 1'b1;
    step();
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_an"}, 32'(bus.an), 32'hF);
    check({tag, "_seg"}, 32'(bus.seg), 32'h7F);
    check({tag, "_dp"}, 32'(bus.dp), 32'h1);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 32'h0);
    check({tag, "_pending"}, 32'(bus.pending), 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    bus.digits = '0; bus.dp_in = '0; bus.blank_in = '0; bus.load = 1'b0;
    bus.lz_en = 1'b0; bus.brightness = 2'd3;
    model_reset();

    // Reset held for three clocks
    repeat (3) @(posedge clock);
    #1;
    check_blank("reset");
    reset = 1'b1;

    // Plain load, full brightness
    do_load(16'h1234, 4'h0, 4'h0);
    run(2 * FRAME + 5);

    // Reset asserted mid-slot: outputs must go dark before any edge
    check("pre_reset_lit", 32'(bus.an != 4'hF), 32'h1);
    #3 reset = 1'b0;
    #1 check_blank("async_reset");
    @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
    run(3);

    // Leading-zero suppression
    bus.lz_en = 1'b1;
    do_load(16'h0050, 4'h0, 4'h0);
    run(2 * FRAME);
    do_load(16'h0000, 4'h0, 4'h0);
    run(2 * FRAME);
    bus.lz_en = 1'b0;

    // Double buffer: two loads in one frame, only the last one shows
    do_load(16'h1234, 4'h0, 4'h0);
    run(2 * FRAME);
    while ((n % FRAME) != 6) step();
    do_load(16'hAAAA, 4'h0, 4'h0);
    run(3);
    do_load(16'h5555, 4'h0, 4'h0);
    run(2 * FRAME);

    // Load exactly on the wrap tick, with decimal point and blanking
    do_load(16'h1111, 4'h0, 4'h0);
    while ((n % FRAME) != FRAME - 1) step();
    do_load(16'hFFFF, 4'b0100, 4'b0001);
    run(2 * FRAME);

    // Brightness levels
    do_load(16'h89AB, 4'h0, 4'h0);
    for (int b = 0; b < 4; b++) begin
      bus.brightness = 2'(b);
      run(FRAME + 3);
    end

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        bus.digits   = 16'($urandom);
        bus.dp_in    = 4'($urandom);
        bus.blank_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        if ($urandom_range(0, 3) == 0) bus.digits = bus.digits & 16'h00FF;
        bus.load = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) bus.lz_en = 1'($urandom);
      if ($urandom_range(0, 19) == 0) bus.brightness = 2'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seven_seg_display_ctrl.md
Name: seven_seg_display_ctrl

Overview:
Parametrised multi-digit seven-segment display controller for the board display path. It contains its own refresh prescaler and scans NUM_DIGITS digits. Display data is double-buffered so updates commit only at frame boundaries, and it adds per-digit decimal points, blanking, leading-zero suppression and PWM brightness. It takes the place of the separate clock_div / seven_seg_scanner / seven_seg_decoder chain under top, and the math block feeds its data inputs.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
DIVIDE_BY, 17, prescaler width; one digit slot lasts 2^DIVIDE_BY clocks
BRIGHT_BITS, 2, brightness resolution; must be <= DIVIDE_BY

Ports:
clock  input  1  system clock (100 MHz on board)
reset  input  1  asynchronous, active-low reset
digits  input  4*NUM_DIGITS  hex nibble per digit; digit 0 = bits [3:0] = rightmost
dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit
blank_in  input  NUM_DIGITS  force digit dark, 1 = blank
load  input  1  one-cycle strobe; captures digits/dp_in/blank_in into the pending buffer
lz_en  input  1  leading-zero suppression enable (live, not buffered)
brightness  input  BRIGHT_BITS  duty level (live, not buffered)
an  output  NUM_DIGITS  anodes, active-low
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
frame_done  output  1  one-cycle pulse when scan wraps from digit NUM_DIGITS-1 to 0
pending  output  1  1 while loaded data awaits commit

Behaviour:
- Clock and reset: the clock port is named clock. The reset port is named reset. Reset is asynchronous and active-low.
- Reset (reset=0, asynchronous) forces the following:
  - prescaler cnt = 0, digit index idx = 0;
  - active and pending buffers all 0, pending = 0;
  - an = all 1s, seg = 7'h7F, dp = 1, frame_done = 0.
  - Reset asserted mid-frame blanks the outputs immediately, without waiting for a clock edge.
- Prescaler:
  - DIVIDE_BY-bit cnt increments every clock and wraps naturally.
  - tick = (cnt == all 1s).
- Scan:
  - On tick, idx increments.
  - idx = NUM_DIGITS-1 wraps to 0. On that same tick frame_done is registered high for exactly one cycle.
- Load:
  - On a load cycle with no wrap, the inputs are captured into pending regs and pending = 1.
  - A repeated load before the wrap overwrites the pending regs (last load wins).
  - At a wrap with pending = 1, pending regs copy to active and pending = 0.
  - load coincident with a wrap tick: the new inputs go straight to active and pending = 0; any older pending data is discarded.
- Suppression: with lz_en = 1, digit i (i >= 1) is dark when active nibble i..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed.
- Lit condition for digit idx: not blank, not suppressed, and PWM on.
  - PWM on = (cnt[DIVIDE_BY-1 -: BRIGHT_BITS] <= brightness).
  - Maximum brightness is 100% duty; brightness = 0 gives a duty of 1/2^BRIGHT_BITS.
- Outputs: registered, one clock after cnt/idx.
  - When lit: an has only bit idx low, seg = hex font of the active nibble, dp = ~active_dp[idx].
  - When not lit: an all 1s, seg = 7'h7F, dp = 1.
  - dp is blanked along with its digit.
- Hex font (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Decomposition:
- Package seven_seg_pkg holds:
  - SEG_OFF = 7'h7F;
  - the 16-entry hex font constant;
  - function hex_to_seg(nibble).
- One combinational sub-module, seven_seg_hex_font (nibble -> seg), instantiated once on the selected digit.
- The prescaler, scanner, buffers and PWM stay in the top controller.

Test Plan:
All scenarios use NUM_DIGITS=4, DIVIDE_BY=2, BRIGHT_BITS=2.
1. Reset: hold reset=0 for 3 clocks -> an=4'hF, seg=7'h7F, dp=1, frame_done=0, pending=0. Assert reset mid-scan -> outputs blank before the next edge.
2. load digits=16'h1234, brightness=3, lz_en=0:
   - pending=1 until the next frame_done, then 0.
   - Next frame shows an=1110/seg=19, 1101/30, 1011/24, 0111/79, each for 4 clocks.
   - frame_done pulses every 16 clocks.
3. Leading zeros: lz_en=1.
   - load 16'h0050 -> digits 3,2 never lit; digit 1 seg=12, digit 0 seg=40.
   - load 16'h0000 -> only digit 0 lit, seg=40.
4. Double buffer: load 16'hAAAA mid-frame, then load 16'h5555 before the wrap -> display unchanged until the wrap, then all digits seg=12; 16'hAAAA is never displayed.
5. load asserted on the wrap-tick cycle with digits=16'hFFFF -> next frame shows seg=0E and pending stays 0. Also set dp_in=4'b0100 and blank_in=4'b0001 -> dp=0 only while an=1011; digit 0 stays dark.
6. brightness=0 -> an is low for 1 of the 4 clocks per slot (cnt==0). brightness=2 -> 3 of 4. brightness=3 -> 4 of 4.
